// File: rtl/present80_seq_ctrl_if.sv
// Datapath-side bundle between the PRESENT-80 sequencer (master) and the round datapath (slave).
interface present80_seq_ctrl_if #(
   parameter int unsigned CTR_W = 5
);
   logic             dp_stall;
   logic [63:0]      dp_state;
   logic             dp_load;
   logic [79:0]      dp_key;
   logic [63:0]      dp_plain;
   logic             dp_round_en;
   logic [CTR_W-1:0] dp_round_ctr;
   logic             dp_final;

   modport master (
      input  dp_stall, dp_state,
      output dp_load, dp_key, dp_plain, dp_round_en, dp_round_ctr, dp_final
   );

   modport slave (
      output dp_stall, dp_state,
      input  dp_load, dp_key, dp_plain, dp_round_en, dp_round_ctr, dp_final
   );
endinterface

// File: rtl/present80_seq_ctrl.sv
// Sequencer for the PRESENT-80 round datapath: load, NUM_ROUNDS rounds, final key add, capture.
module present80_seq_ctrl #(
   parameter int unsigned NUM_ROUNDS = 31,
   parameter int unsigned CTR_W      = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic                        done_clr_i,
   input  logic [79:0]                 key_i,
   input  logic [63:0]                 plain_i,
   present80_seq_ctrl_if.master        dp_io,
   output logic [63:0]                 cipher_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o,
   output logic                        irq_o
);

   typedef enum logic [2:0] {StIdle, StLoad, StRound, StFinal, StCapt} state_e;

   localparam logic [CTR_W-1:0] LastRound = CTR_W'(NUM_ROUNDS);
   localparam logic [CTR_W-1:0] FirstRound = CTR_W'(1);

   state_e           state_q;
   logic [CTR_W-1:0] ctr_q;
   logic [79:0]      key_q;
   logic [63:0]      plain_q;
   logic [63:0]      cipher_q;
   logic             load_q, busy_q, done_q, err_q, irq_q;
   logic             round_en, final_en;

   // Round and final strobes follow dp_stall combinationally so a stall freezes the same cycle.
   assign round_en = (state_q == StRound) && !dp_io.dp_stall;
   assign final_en = (state_q == StFinal) && !dp_io.dp_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ctr_q    <= FirstRound;
         key_q    <= '0;
         plain_q  <= '0;
         cipher_q <= '0;
         load_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_q  <= 1'b0;
         load_q <= 1'b0;
         if (done_clr_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end
         if (state_q != StIdle && abort_i) begin
            state_q <= StIdle;
            ctr_q   <= FirstRound;
            busy_q  <= 1'b0;
         end else begin
            // A start while busy is dropped but leaves a sticky error.
            if (start_i && state_q != StIdle) err_q <= 1'b1;
            unique case (state_q)
               StIdle: begin
                  if (start_i) begin
                     key_q   <= key_i;
                     plain_q <= plain_i;
                     done_q  <= 1'b0;
                     load_q  <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= StLoad;
                  end
               end
               StLoad: begin
                  ctr_q   <= FirstRound;
                  state_q <= StRound;
               end
               StRound: begin
                  if (round_en) begin
                     if (ctr_q == LastRound) begin
                        ctr_q   <= FirstRound;
                        state_q <= StFinal;
                     end else begin
                        ctr_q <= ctr_q + 1'b1;
                     end
                  end
               end
               StFinal: begin
                  if (final_en) state_q <= StCapt;
               end
               StCapt: begin
                  cipher_q <= dp_io.dp_state;
                  done_q   <= 1'b1;
                  irq_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign dp_io.dp_load      = load_q;
   assign dp_io.dp_key       = key_q;
   assign dp_io.dp_plain     = plain_q;
   assign dp_io.dp_round_en  = round_en;
   assign dp_io.dp_round_ctr = (state_q == StRound) ? ctr_q : '0;
   assign dp_io.dp_final     = final_en;

   assign cipher_o = cipher_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign irq_o    = irq_q;

endmodule
